// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants for the FIFO read-side stream adapter: word width,
// output-buffer occupancy encodings and the dequeue credit rule.
package fifo_rd_stream_pkg;

    localparam int STREAM_DATA_WIDTH = 64;
    localparam int BUF_ENTRIES       = 2;

    // Buffer occupancy doubles as the FSM state.
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // A new dequeue is allowed only if every word already owned, after this
    // cycle's pop, still leaves a free buffer slot for the new word.
    function automatic logic credit_avail(input logic [1:0] occ,
                                          input logic       inflight,
                                          input logic       pop);
        logic [2:0] owned;
        owned = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return (owned <= 3'd1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered read port: rdata is valid the cycle
// after dequeue. Storage has no reset so it maps onto block RAM.
module sync_fifo #(
    parameter int DATA_WIDTH  = 64,
    parameter int QUEUE_DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enqueue,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic                           dequeue,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           is_empty,
    output logic                           is_full,
    output logic [$clog2(QUEUE_DEPTH):0]   count
);

    localparam int AW = $clog2(QUEUE_DEPTH);

    logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
    logic [AW-1:0]         wr_ptr_reg;
    logic [AW-1:0]         rd_ptr_reg;
    logic [AW:0]           count_reg;
    logic [AW:0]           count_next;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  do_enq;
    logic                  do_deq;

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == (AW+1)'(QUEUE_DEPTH));
    assign count    = count_reg;
    assign rdata    = rdata_reg;

    assign do_enq = enqueue && !is_full;
    assign do_deq = dequeue && !is_empty;

    assign count_next = count_reg + (AW+1)'(do_enq) - (AW+1)'(do_deq);

    always_ff @(posedge clk) begin
        if (do_enq) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rdata_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (do_enq) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_deq) begin
                rdata_reg  <= mem[rd_ptr_reg];
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for sync_fifo: absorbs the FIFO's one-cycle read latency
// with a 2-entry buffer and presents the words as a valid/ready stream.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = STREAM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_is_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_dequeue,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [1:0]            pending
);

    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;
    logic                  inflight_reg;
    logic                  head_reg;
    logic                  tail_reg;
    logic                  pop;
    logic                  capture;
    logic [DATA_WIDTH-1:0] buf_q [BUF_ENTRIES];

    assign out_valid = (occ_reg != OCC_EMPTY) && !flush;
    assign pop       = out_valid && out_ready;
    assign capture   = inflight_reg && !flush;
    assign out_data  = buf_q[head_reg];
    // Occupancy plus in-flight never exceeds 2, so 2 bits cannot wrap.
    assign pending   = occ_reg + {1'b0, inflight_reg};

    // Gating with rst_n keeps the FIFO untouched while the block is held in reset.
    assign fifo_dequeue = rst_n && !fifo_is_empty && !flush
                          && credit_avail(occ_reg, inflight_reg, pop);

    always_comb begin
        occ_next = occ_reg;
        case (occ_reg)
            OCC_EMPTY: begin
                if (capture) begin
                    occ_next = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (capture && !pop) begin
                    occ_next = OCC_TWO;
                end else if (!capture && pop) begin
                    occ_next = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop && !capture) begin
                    occ_next = OCC_ONE;
                end
            end
            default: begin
                occ_next = OCC_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg      <= OCC_EMPTY;
            inflight_reg <= 1'b0;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
        end else if (flush) begin
            occ_reg      <= OCC_EMPTY;
            inflight_reg <= 1'b0;
            head_reg     <= 1'b0;
            tail_reg     <= 1'b0;
        end else begin
            occ_reg      <= occ_next;
            inflight_reg <= fifo_dequeue;
            if (pop) begin
                head_reg <= ~head_reg;
            end
            if (capture) begin
                tail_reg <= ~tail_reg;
            end
        end
    end

    // Buffer entries survive flush; only the pointers and occupancy are cleared.
    genvar gi;
    generate
        for (gi = 0; gi < BUF_ENTRIES; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (capture && (tail_reg == 1'(gi))) begin
                    entry_reg <= fifo_rdata;
                end
            end

            assign buf_q[gi] = entry_reg;
        end
    endgenerate

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter for the core's `sync_fifo` queues: it drives the FIFO's `dequeue` and absorbs its one-cycle registered `rdata` latency. It presents the dequeued words to a downstream consumer, such as decode or issue, as a valid/ready stream. A 2-entry output buffer, together with an in-flight credit, sustains one word per cycle with no combinational path from `out_ready` to `fifo_dequeue` beyond the credit check. `flush` discards everything held locally, for pipeline squash.

## Interface
- `DATA_WIDTH`, 64, width of FIFO words and `out_data`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `fifo_is_empty`  in  1  FIFO empty flag.
- `fifo_rdata`  in  DATA_WIDTH  FIFO registered read data; valid the cycle after a dequeue.
- `fifo_dequeue`  out  1  dequeue request to the FIFO (combinational).
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_data`  out  DATA_WIDTH  head word of the output buffer.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `flush`  in  1  drop all buffered and in-flight words.
- `pending`  out  2  `occ` + `inflight_r`, the words owned by the block (0..2).

## Operation
- State:
  - `occ` (0..2) forms the buffer FSM, with states EMPTY, ONE and TWO.
  - `inflight_r` (1 bit) marks that `fifo_rdata` carries a word this cycle.
  - `head_r`/`tail_r` are 1-bit pointers into `buf[2]`.
- Definitions:
  - `pop` = `out_valid && out_ready`.
  - `out_valid` = (`occ` != 0) && ~`flush`.
  - `out_data` = `buf[head_r]`, always, even when invalid.
- Dequeue rule: `fifo_dequeue` = ~`fifo_is_empty` && ~`flush` && (`occ` + `inflight_r` − `pop` ≤ 1).
  - Computed at 2-bit or wider width, so no underflow.
  - This guarantees a buffer slot for every in-flight word.
- Next-state rules:
  - `inflight_r` <= `fifo_dequeue`.
  - Capture: if `inflight_r` && ~`flush`, write `fifo_rdata` into `buf[tail_r]` and toggle `tail_r`.
  - Pop: if `pop`, toggle `head_r`.
  - `occ` <= `occ` + capture − `pop`. Capture and pop in the same cycle leave `occ` unchanged.
- Flush: `occ`, `head_r`, `tail_r` and `inflight_r` all go to 0 at the next edge.
  - A word arriving on `fifo_rdata` the cycle after flush is not captured, because `inflight_r` was cleared.
  - `buf` contents are not cleared.
  - The FIFO itself is not flushed; that is the owner's job.
- Overflow: capture with `occ` == 2 is impossible by construction. The bench asserts it never happens.
- Transitions:
  - EMPTY→ONE on capture.
  - ONE→TWO on capture without pop.
  - TWO→ONE on pop.
  - ONE→EMPTY on pop without capture.
  - Any state →EMPTY on flush.

## Timing
- Reset, asynchronous and active-low. While `rst_n` = 0:
  - `occ`, `inflight_r`, `head_r` and `tail_r` are 0, and `buf` entries are 0.
  - `out_valid` = 0 and `out_data` = 0.
  - `pending` = 0.
  - `fifo_dequeue` = 0, forced.
- Latency: FIFO non-empty in cycle T with `occ` = 0 and `inflight_r` = 0:
  - `fifo_dequeue` is asserted in T.
  - The word is on `fifo_rdata` in T+1.
  - `out_valid` with that word appears in T+2.
- Throughput: with a continuously non-empty FIFO and `out_ready` = 1, one word is output per cycle from T+2 on.
- Backpressure: with `out_ready` = 0, at most 2 words are absorbed; `fifo_dequeue` then stays 0.
- Ordering: output order equals FIFO order; no loss or duplication except by flush.
- Reset mid-operation: all state is lost immediately, and outputs take their reset values asynchronously.

## Structure
- Module is self-contained; no sub-module.
- No shared-package types required.
  - The FSM is implicit in `occ`.
  - If the core package defines a stream word type, `DATA_WIDTH` follows it.
- The bench instantiates `sync_fifo` (QUEUE_DEPTH 16) upstream and connects it to this block.

## Test plan
- Reset, then idle with the FIFO empty → `out_valid` = 0, `fifo_dequeue` = 0, `pending` = 0, `out_data` = 0.
- Enqueue 0x11 at T0, `out_ready` = 1 → `fifo_dequeue` in T1, `out_valid` with 0x11 in T3, `pending` back to 0 in T4.
- Preload 8 words 0x1..0x8, `out_ready` held 1 → 0x1..0x8 on 8 consecutive cycles, one per cycle, in order.
- Preload 5 words, `out_ready` = 0 for 10 cycles → `pending` saturates at 2, FIFO count = 3. Then `out_ready` = 1 → remaining words emerge in order, with no loss or duplication.
- Preload 6 words, `out_ready` = 1, assert `flush` for 1 cycle mid-stream →
  - `out_valid` = 0 in the flush cycle and the following cycle.
  - The in-flight word is dropped.
  - Output resumes with the next un-dequeued FIFO word.
- Assert `rst_n` = 0 asynchronously while `occ` = 2 → `out_valid` and `pending` drop immediately. After release, the remaining FIFO words stream normally; the FIFO is reset with the block.
